// File: rtl/neuron_tdm_scheduler_pkg.sv
// Shared types, field widths and saturating arithmetic for the time-multiplexed
// leaky integrate-and-fire scheduler.
package neuron_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAK,
    ACC0,
    ACC1,
    CMP,
    DONE
  } state_t;

  localparam logic [1:0] SEL_W0  = 2'd0;
  localparam logic [1:0] SEL_W1  = 2'd1;
  localparam logic [1:0] SEL_THR = 2'd2;
  localparam logic [1:0] SEL_CLR = 2'd3;

  localparam int V_W_DEF = 10;
  localparam int WGT_W   = 4;
  localparam int IN_W    = 4;
  localparam int THR_W   = 8;
  localparam int CFG_W   = 8;

  // Operands are small enough that a 32-bit sum never wraps before clamping.
  function automatic int sat_add(input int a, input int b, input int vw);
    int sum;
    int hi;
    int lo;
    sum = a + b;
    hi  = (1 <<< (vw - 1)) - 1;
    lo  = -(1 <<< (vw - 1));
    if (sum > hi) begin
      return hi;
    end
    if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/neuron_tdm_scheduler_if.sv
// Input/config/spike bundle between the pin wrapper and the neuron scheduler.
interface neuron_tdm_scheduler_if
  import neuron_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int V_W       = V_W_DEF
);
  localparam int AW = $clog2(N_NEURONS);

  logic                  tick_i;
  logic [IN_W-1:0]       x0_i;
  logic [IN_W-1:0]       x1_i;
  logic                  cfg_we_i;
  logic [AW-1:0]         cfg_addr_i;
  logic [1:0]            cfg_sel_i;
  logic [CFG_W-1:0]      cfg_data_i;
  logic signed [V_W-1:0] vmem_o;
  logic                  busy_o;
  logic                  done_o;
  logic [N_NEURONS-1:0]  spike_o;

  modport master (
    output tick_i, x0_i, x1_i, cfg_we_i, cfg_addr_i, cfg_sel_i, cfg_data_i,
    input  vmem_o, busy_o, done_o, spike_o
  );

  modport slave (
    input  tick_i, x0_i, x1_i, cfg_we_i, cfg_addr_i, cfg_sel_i, cfg_data_i,
    output vmem_o, busy_o, done_o, spike_o
  );

endinterface

// File: rtl/neuron_lif_alu.sv
// Registered accumulator that performs leak, the two weighted accumulates and the
// threshold compare for whichever neuron the scheduler is currently visiting.
module neuron_lif_alu
  import neuron_pkg::*;
#(
  parameter int V_W        = V_W_DEF,
  parameter int LEAK_SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  state_t                  op,
  input  logic signed [V_W-1:0]   v,
  input  logic signed [WGT_W-1:0] w,
  input  logic [IN_W-1:0]         x,
  input  logic signed [THR_W-1:0] thr,
  output logic signed [V_W-1:0]   acc,
  output logic                    fire
);

  logic signed [WGT_W+IN_W:0] prod;
  logic signed [V_W-1:0]      leak_val;
  int                         sum;

  // The input is unsigned, so it gets a zero sign bit before the signed multiply.
  assign prod     = w * $signed({1'b0, x});
  assign leak_val = v - (v >>> LEAK_SHIFT);
  assign sum      = sat_add(int'(acc), int'(prod), V_W);
  assign fire     = int'(acc) >= int'(thr);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else begin
      case (op)
        LEAK:       acc <= leak_val;
        ACC0, ACC1: acc <= sum[V_W-1:0];
        default:    acc <= acc;
      endcase
    end
  end

endmodule

// File: rtl/neuron_tdm_scheduler.sv
// Sequences N_NEURONS virtual LIF neurons through one shared ALU per tick and
// owns the weight, threshold and membrane register files.
module neuron_tdm_scheduler
  import neuron_pkg::*;
#(
  parameter int N_NEURONS  = 4,
  parameter int LEAK_SHIFT = 2,
  parameter int V_W        = V_W_DEF,
  parameter int THRESH_DEF = 8
) (
  input logic                   clk,
  input logic                   rst,
  neuron_tdm_scheduler_if.slave bus
);

  localparam int AW = $clog2(N_NEURONS);

  state_t                  state_reg;
  logic [AW-1:0]           idx_reg;
  logic [IN_W-1:0]         x0_reg;
  logic [IN_W-1:0]         x1_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic [N_NEURONS-1:0]    spike_reg;
  logic [N_NEURONS-1:0]    spk_reg;
  logic [N_NEURONS-1:0]    spk_next;
  logic signed [V_W-1:0]   v_reg   [N_NEURONS];
  logic signed [WGT_W-1:0] w0_reg  [N_NEURONS];
  logic signed [WGT_W-1:0] w1_reg  [N_NEURONS];
  logic signed [THR_W-1:0] thr_reg [N_NEURONS];

  logic signed [WGT_W-1:0] alu_w;
  logic [IN_W-1:0]         alu_x;
  logic signed [V_W-1:0]   alu_acc;
  logic                    fire;
  logic                    cfg_ok;
  logic                    last;

  assign alu_w  = (state_reg == ACC1) ? w1_reg[idx_reg] : w0_reg[idx_reg];
  assign alu_x  = (state_reg == ACC1) ? x1_reg : x0_reg;
  assign last   = (idx_reg == AW'(N_NEURONS - 1));
  assign cfg_ok = bus.cfg_we_i && (state_reg == IDLE) && (int'(bus.cfg_addr_i) < N_NEURONS);

  neuron_lif_alu #(
    .V_W        (V_W),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_alu (
    .clk  (clk),
    .rst  (rst),
    .op   (state_reg),
    .v    (v_reg[idx_reg]),
    .w    (alu_w),
    .x    (alu_x),
    .thr  (thr_reg[idx_reg]),
    .acc  (alu_acc),
    .fire (fire)
  );

  // Folds the final neuron's decision in so spike_o is valid alongside done_o.
  always_comb begin
    spk_next          = spk_reg;
    spk_next[idx_reg] = fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      x0_reg    <= '0;
      x1_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      spike_reg <= '0;
      spk_reg   <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_reg[i]   <= '0;
        w0_reg[i]  <= '0;
        w1_reg[i]  <= '0;
        thr_reg[i] <= THR_W'(THRESH_DEF);
      end
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.tick_i) begin
            x0_reg    <= bus.x0_i;
            x1_reg    <= bus.x1_i;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= LEAK;
          end
        end
        LEAK: state_reg <= ACC0;
        ACC0: state_reg <= ACC1;
        ACC1: state_reg <= CMP;
        CMP: begin
          v_reg[idx_reg]   <= fire ? '0 : alu_acc;
          spk_reg[idx_reg] <= fire;
          if (last) begin
            spike_reg <= spk_next;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg   <= idx_reg + 1'b1;
            state_reg <= LEAK;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      if (cfg_ok) begin
        case (bus.cfg_sel_i)
          SEL_W0:  w0_reg[bus.cfg_addr_i]  <= $signed(bus.cfg_data_i[WGT_W-1:0]);
          SEL_W1:  w1_reg[bus.cfg_addr_i]  <= $signed(bus.cfg_data_i[WGT_W-1:0]);
          SEL_THR: thr_reg[bus.cfg_addr_i] <= $signed(bus.cfg_data_i[THR_W-1:0]);
          default: v_reg[bus.cfg_addr_i]   <= '0;
        endcase
      end
    end
  end

  assign bus.vmem_o  = v_reg[bus.cfg_addr_i];
  assign bus.busy_o  = busy_reg;
  assign bus.done_o  = done_reg;
  assign bus.spike_o = spike_reg;

endmodule

// File: tb/tb_neuron_tdm_scheduler.sv
// Directed, table-driven bench for neuron_tdm_scheduler (N=4, LEAK_SHIFT=2, V_W=10).
module tb_neuron_tdm_scheduler;
  import neuron_pkg::*;

  localparam int N = 4;

  typedef struct {
    string      name;
    bit         is_pass;
    logic [1:0] addr;
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] x0;
    logic [3:0] x1;
    logic [3:0] exp_spike;
    bit         chk;
    logic [1:0] probe;
    int         exp_vmem;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  row_t rows[$];

  neuron_tdm_scheduler_if #(.N_NEURONS(N), .V_W(10)) bus ();

  neuron_tdm_scheduler #(
    .N_NEURONS  (N),
    .LEAK_SHIFT (2),
    .V_W        (10),
    .THRESH_DEF (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic row_t pass_row(string n, logic [3:0] a, logic [3:0] b,
                                    logic [3:0] sp, logic [1:0] pr, int ev);
    row_t r;
    r = '{name: n, is_pass: 1'b1, addr: 2'd0, sel: 2'd0, data: 8'd0, x0: a, x1: b,
          exp_spike: sp, chk: 1'b1, probe: pr, exp_vmem: ev};
    return r;
  endfunction

  function automatic row_t cfg_row(string n, logic [1:0] ad, logic [1:0] s, logic [7:0] d,
                                   bit c, logic [1:0] pr, int ev);
    row_t r;
    r = '{name: n, is_pass: 1'b0, addr: ad, sel: s, data: d, x0: 4'd0, x1: 4'd0,
          exp_spike: 4'd0, chk: c, probe: pr, exp_vmem: ev};
    return r;
  endfunction

  task automatic check(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic read_vmem(input logic [1:0] a, output int v);
    bus.cfg_addr_i = a;
    #1;
    v = int'($signed(bus.vmem_o));
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [1:0] s, input logic [7:0] d);
    @(negedge clk);
    bus.cfg_we_i   = 1'b1;
    bus.cfg_addr_i = a;
    bus.cfg_sel_i  = s;
    bus.cfg_data_i = d;
    @(negedge clk);
    bus.cfg_we_i = 1'b0;
  endtask

  // A tick raised in the DONE cycle must not start another pass.
  task automatic do_pass(input logic [3:0] a, input logic [3:0] b, output int busy_cnt,
                         output bit done_seen, output bit busy_after);
    @(negedge clk);
    bus.x0_i   = a;
    bus.x1_i   = b;
    bus.tick_i = 1'b1;
    @(negedge clk);
    bus.tick_i = 1'b0;
    bus.x0_i   = ~a;
    bus.x1_i   = ~b;
    busy_cnt   = 0;
    done_seen  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o) begin
        done_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.tick_i = 1'b1;
    @(negedge clk);
    bus.tick_i = 1'b0;
    busy_after = bus.busy_o;
  endtask

  task automatic run_row(input row_t r);
    int bc;
    bit dn;
    bit ba;
    int v;
    if (r.is_pass) begin
      do_pass(r.x0, r.x1, bc, dn, ba);
      check({r.name, " busy_cycles"}, bc, 16);
      check({r.name, " done"}, int'(dn), 1);
      check({r.name, " busy_after_done_tick"}, int'(ba), 0);
      check({r.name, " spike"}, int'(bus.spike_o), int'(r.exp_spike));
    end else begin
      cfg_write(r.addr, r.sel, r.data);
    end
    if (r.chk) begin
      read_vmem(r.probe, v);
      check({r.name, " vmem"}, v, r.exp_vmem);
      $display("row %s x0=%0d x1=%0d spike=%b vmem[%0d]=%0d", r.name, r.x0, r.x1,
               bus.spike_o, r.probe, v);
    end else begin
      $display("row %s cfg addr=%0d sel=%0d data=%0h", r.name, r.addr, r.sel, r.data);
    end
  endtask

  initial begin
    int v;
    int busy_cnt;
    int done_cnt;

    bus.tick_i     = 1'b0;
    bus.x0_i       = '0;
    bus.x1_i       = '0;
    bus.cfg_we_i   = 1'b0;
    bus.cfg_addr_i = '0;
    bus.cfg_sel_i  = '0;
    bus.cfg_data_i = '0;

    rows.push_back(pass_row("t1_zero_w", 4'd2, 4'd1, 4'b0000, 2'd0, 0));
    rows.push_back(cfg_row("n0_w0", 2'd0, SEL_W0, 8'h03, 1'b0, 2'd0, 0));
    rows.push_back(cfg_row("n0_w1", 2'd0, SEL_W1, 8'h02, 1'b0, 2'd0, 0));
    rows.push_back(cfg_row("n0_thr", 2'd0, SEL_THR, 8'd8, 1'b0, 2'd0, 0));
    rows.push_back(pass_row("t2_fire_eq_thr", 4'd2, 4'd1, 4'b0001, 2'd0, 0));
    rows.push_back(cfg_row("n1_w0", 2'd1, SEL_W0, 8'h01, 1'b0, 2'd0, 0));
    rows.push_back(cfg_row("n1_thr", 2'd1, SEL_THR, 8'd10, 1'b0, 2'd0, 0));
    rows.push_back(pass_row("t3_tick1", 4'd4, 4'd0, 4'b0001, 2'd1, 4));
    rows.push_back(pass_row("t3_tick2", 4'd4, 4'd0, 4'b0001, 2'd1, 7));
    rows.push_back(pass_row("t3_tick3", 4'd4, 4'd0, 4'b0011, 2'd1, 0));
    rows.push_back(cfg_row("n2_w0", 2'd2, SEL_W0, 8'h08, 1'b0, 2'd0, 0));
    rows.push_back(cfg_row("n2_w1", 2'd2, SEL_W1, 8'h08, 1'b0, 2'd0, 0));
    rows.push_back(pass_row("t4_tick1", 4'd15, 4'd15, 4'b0011, 2'd2, -240));
    rows.push_back(pass_row("t4_tick2", 4'd15, 4'd15, 4'b0011, 2'd2, -420));
    rows.push_back(pass_row("t4_sat", 4'd15, 4'd15, 4'b0011, 2'd2, -512));
    rows.push_back(pass_row("t5_w0_kept", 4'd1, 4'd0, 4'b0000, 2'd0, 3));
    rows.push_back(cfg_row("t5_n2_probe", 2'd3, SEL_W1, 8'h00, 1'b1, 2'd2, -392));
    rows.push_back(pass_row("t5_refire", 4'd15, 4'd15, 4'b0011, 2'd2, -512));
    rows.push_back(cfg_row("t6_n0_w0", 2'd0, SEL_W0, 8'h02, 1'b0, 2'd0, 0));
    rows.push_back(cfg_row("t6_n1_w0", 2'd1, SEL_W0, 8'h01, 1'b0, 2'd0, 0));
    rows.push_back(pass_row("t6_thr_def1", 4'd4, 4'd0, 4'b0001, 2'd1, 4));
    rows.push_back(pass_row("t6_thr_def2", 4'd4, 4'd0, 4'b0001, 2'd1, 7));
    rows.push_back(cfg_row("t6_clear_n1", 2'd1, SEL_CLR, 8'hFF, 1'b1, 2'd1, 0));
    rows.push_back(cfg_row("t6_n0_after", 2'd2, SEL_W0, 8'h00, 1'b1, 2'd0, 0));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", int'(bus.busy_o), 0);
    check("reset done", int'(bus.done_o), 0);
    check("reset spike", int'(bus.spike_o), 0);
    for (int i = 0; i < N; i++) begin
      read_vmem(2'(i), v);
      check($sformatf("reset vmem%0d", i), v, 0);
    end
    $display("reset busy=%b done=%b spike=%b", bus.busy_o, bus.done_o, bus.spike_o);

    for (int i = 0; i <= 14; i++) run_row(rows[i]);

    // Mid-pass tick and config writes must all be dropped.
    @(negedge clk);
    bus.x0_i   = 4'd15;
    bus.x1_i   = 4'd15;
    bus.tick_i = 1'b1;
    @(negedge clk);
    bus.tick_i = 1'b0;
    busy_cnt   = 0;
    done_cnt   = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o) done_cnt++;
      if (c == 2) begin
        bus.tick_i     = 1'b1;
        bus.cfg_we_i   = 1'b1;
        bus.cfg_addr_i = 2'd0;
        bus.cfg_sel_i  = SEL_W0;
        bus.cfg_data_i = 8'h07;
      end else if (c == 3) begin
        bus.tick_i     = 1'b0;
        bus.cfg_addr_i = 2'd2;
        bus.cfg_sel_i  = SEL_CLR;
      end else if (c == 4) begin
        bus.cfg_we_i = 1'b0;
      end
      @(negedge clk);
    end
    check("t5 busy_cycles", busy_cnt, 16);
    check("t5 done_count", done_cnt, 1);
    read_vmem(2'd2, v);
    check("t5 n2_not_cleared", v, -512);
    $display("t5 busy_cycles=%0d done_count=%0d vmem[2]=%0d", busy_cnt, done_cnt, v);

    for (int i = 15; i <= 17; i++) run_row(rows[i]);

    // Reset in the middle of a pass: immediate abort, no done pulse.
    cfg_write(2'd0, SEL_THR, 8'd20);
    @(negedge clk);
    bus.x0_i   = 4'd4;
    bus.x1_i   = 4'd0;
    bus.tick_i = 1'b1;
    @(negedge clk);
    bus.tick_i = 1'b0;
    repeat (4) @(negedge clk);
    check("t6 busy_before_rst", int'(bus.busy_o), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6 busy_after_rst", int'(bus.busy_o), 0);
    check("t6 spike_after_rst", int'(bus.spike_o), 0);
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done_o) done_cnt++;
      if (bus.busy_o) busy_cnt++;
      @(negedge clk);
    end
    check("t6 no_done", done_cnt, 0);
    check("t6 stays_idle", busy_cnt, 0);
    read_vmem(2'd2, v);
    check("t6 vmem2_reset", v, 0);
    $display("t6 rst mid-pass done_count=%0d busy_cycles=%0d vmem[2]=%0d", done_cnt, busy_cnt, v);

    for (int i = 18; i < rows.size(); i++) run_row(rows[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
